// File: rtl/sum_uart_pkg.sv
// sum_uart_pkg: shared FSM states and widths for the sum-and-transmit UART.
package sum_uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int SUM_W = 9;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SUM_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
endpackage

// File: rtl/sum_uart_baud.sv
// sum_uart_baud: per-bit cycle counter, pulses bit_done on the last cycle of each serial bit.
module sum_uart_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic bit_done
);
  logic [9:0] cnt_q, cnt_d;
  assign bit_done = en & (cnt_q == 10'(CLKS_PER_BIT - 1));
  always_comb cnt_d = (restart | ~en | bit_done) ? '0 : cnt_q + 10'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sum_uart_tx.sv
// sum_uart_tx: adds two bytes and sends the low 8 sum bits as a UART frame; carry holds bit 8.
// Define SUM_UART_PARITY_EN to insert an even-parity bit between DATA and STOP.
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       carry
);
  state_t state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [2:0] bit_q, bit_d;
  logic tx_q, tx_d, busy_q, busy_d, rdy_q, rdy_d, carry_q, carry_d;
  logic xfer, bit_done;
  logic [SUM_W-1:0] sum;
`ifdef SUM_UART_PARITY_EN
  logic par_q, par_d;
`endif
  assign sum = SUM_W'(op_a) + SUM_W'(op_b);
  assign xfer = in_valid & rdy_q;
  assign in_ready = rdy_q;
  assign tx = tx_q;
  assign busy = busy_q;
  assign carry = carry_q;
  sum_uart_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rst(rst), .restart(xfer), .en(busy_q), .bit_done(bit_done)
  );
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bit_d = bit_q;
    carry_d = carry_q;
    if (xfer) begin
      state_d = START;
      sh_d = sum[DATA_BITS-1:0];
      bit_d = '0;
      carry_d = sum[SUM_W-1];
    end else if (bit_done) begin
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          sh_d = sh_q >> 1;
          bit_d = bit_q + 3'd1;
`ifdef SUM_UART_PARITY_EN
          if (bit_q == 3'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: state_d = STOP;
`else
          if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
`ifdef SUM_UART_PARITY_EN
    par_d = xfer ? ^sum[DATA_BITS-1:0] : par_q;
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : (state_d == PARITY) ? par_q : 1'b1;
`else
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
`endif
    busy_d = state_d != IDLE;
    rdy_d = state_d == IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      bit_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      rdy_q <= 1'b0;
      carry_q <= 1'b0;
`ifdef SUM_UART_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      rdy_q <= rdy_d;
      carry_q <= carry_d;
`ifdef SUM_UART_PARITY_EN
      par_q <= par_d;
`endif
    end
endmodule
